// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - single-packet inbound/outbound NIC between a core's mapped port and its ring router
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STATUS = ADDR_WIDTH'(3);

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;

    logic proc_rd;
    logic proc_wr;
    logic pop;
    logic capture;
    logic load;

    assign proc_rd = nicEn & ~nicWrEn;
    assign proc_wr = nicEn & nicWrEn;
    assign pop     = proc_rd & (addr == ADDR_IN_BUF);
    assign net_ri  = ~in_full;
    assign capture = net_si & net_ri;
    // Only sends on the ring phase that matches the packet's virtual channel.
    assign net_so  = out_full & net_ro & (net_polarity == out_buf[VC_BIT]);
    assign net_do  = net_so ? out_buf : '0;
    assign load    = proc_wr & (addr == ADDR_OUT_BUF) & ~out_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (capture) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end else if (pop) begin
            // Destructive pop clears status only; in_buf stays readable.
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (net_so) begin
            out_full <= 1'b0;
        end else if (load) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

    always_comb begin
        d_out = '0;
        if (proc_rd) begin
            case (addr)
                ADDR_IN_BUF:     d_out = in_buf;
                ADDR_IN_STATUS:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:    d_out = out_buf;
                ADDR_OUT_STATUS: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:         d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - directed self-checking bench for cardinal_nic
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] PKT_A = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] PKT_B = 64'h8000_0000_0000_00C3;
    localparam logic [63:0] PKT_C = 64'h0000_0000_0000_1111;
    localparam logic [63:0] PKT_D = 64'h0000_0000_0000_2222;
    localparam logic [63:0] PKT_E = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_F = 64'h7EAD_BEEF_0000_0042;
    localparam logic [63:0] PKT_G = 64'h5555_AAAA_5555_AAAA;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
        #1;
    endtask

    task automatic idle();
        nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
        #1;
    endtask

    initial begin
        reset = 1'b0; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        tick(); tick();
        check("rst_ri", {63'b0, net_ri}, 64'd1);
        check("rst_so", {63'b0, net_so}, 64'd0);
        check("rst_do", net_do, 64'd0);
        rd(2'b01); check("rst_in_status", d_out, 64'd0);
        rd(2'b11); check("rst_out_status", d_out, 64'd0);
        idle();
        reset = 1'b1;
        tick();

        // inbound capture, status, destructive pop
        net_si = 1'b1; net_di = PKT_A;
        tick();
        net_si = 1'b0; net_di = '0;
        check("in_ri_after_cap", {63'b0, net_ri}, 64'd0);
        rd(2'b01); check("in_status_full", d_out, 64'd1);
        rd(2'b00); check("in_buf_data", d_out, PKT_A);
        tick();
        rd(2'b01); check("in_status_popped", d_out, 64'd0);
        check("in_ri_after_pop", {63'b0, net_ri}, 64'd1);
        rd(2'b00); check("in_buf_stale", d_out, PKT_A);
        tick();
        rd(2'b01); check("stale_pop_no_change", d_out, 64'd0);
        wr(2'b00, PKT_G);
        tick();
        idle();
        rd(2'b00); check("wr00_ignored", d_out, PKT_A);
        idle();

        // outbound waits for matching VC polarity
        net_ro = 1'b1; net_polarity = 1'b0;
        wr(2'b10, PKT_B);
        tick();
        idle();
        check("out_so_wrong_pol", {63'b0, net_so}, 64'd0);
        check("out_do_wrong_pol", net_do, 64'd0);
        rd(2'b11); check("out_status_full", d_out, 64'd1);
        idle();
        net_polarity = 1'b1;
        #1;
        check("out_so_match", {63'b0, net_so}, 64'd1);
        check("out_do_match", net_do, PKT_B);
        tick();
        rd(2'b11); check("out_status_sent", d_out, 64'd0);
        check("out_so_after_send", {63'b0, net_so}, 64'd0);
        idle();

        // write to full out_buf is dropped
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, PKT_C);
        tick();
        wr(2'b10, PKT_D);
        tick();
        rd(2'b10); check("out_full_drop", d_out, PKT_C);
        rd(2'b11); check("out_full_status", d_out, 64'd1);
        idle();
        // send and write in the same cycle: write dropped
        net_ro = 1'b1;
        wr(2'b10, PKT_E);
        check("send_wr_so", {63'b0, net_so}, 64'd1);
        tick();
        rd(2'b11); check("send_wr_status", d_out, 64'd0);
        rd(2'b10); check("send_wr_buf", d_out, PKT_C);
        idle();
        net_ro = 1'b0;

        // pop and net_si in the same cycle
        net_si = 1'b1; net_di = PKT_C;
        tick();
        net_di = PKT_D;
        rd(2'b00); check("pop_si_old", d_out, PKT_C);
        tick();
        net_si = 1'b0; net_di = '0;
        idle();
        rd(2'b01); check("pop_si_not_cap", d_out, 64'd0);
        check("pop_si_ri", {63'b0, net_ri}, 64'd1);
        idle();
        net_si = 1'b1; net_di = PKT_D;
        tick();
        net_si = 1'b0; net_di = '0;
        rd(2'b00); check("pop_si_next_cap", d_out, PKT_D);
        tick();
        idle();

        // simultaneous send and inbound capture
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, PKT_E);
        tick();
        idle();
        net_ro = 1'b1; net_si = 1'b1; net_di = PKT_F;
        #1;
        check("both_so", {63'b0, net_so}, 64'd1);
        check("both_ri", {63'b0, net_ri}, 64'd1);
        tick();
        net_si = 1'b0; net_di = '0; net_ro = 1'b0;
        rd(2'b11); check("both_out_status", d_out, 64'd0);
        rd(2'b01); check("both_in_status", d_out, 64'd1);
        idle();

        // async reset mid-cycle with both buffers full
        wr(2'b10, PKT_E);
        tick();
        net_ro = 1'b1;
        rd(2'b00);
        check("pre_rst_so", {63'b0, net_so}, 64'd1);
        check("pre_rst_dout", d_out, PKT_F);
        check("pre_rst_ri", {63'b0, net_ri}, 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_ri", {63'b0, net_ri}, 64'd1);
        check("async_rst_so", {63'b0, net_so}, 64'd0);
        check("async_rst_do", net_do, 64'd0);
        check("async_rst_dout", d_out, 64'd0);
        idle();
        tick();
        reset = 1'b1;
        tick();
        rd(2'b01); check("post_rst_in_status", d_out, 64'd0);
        rd(2'b11); check("post_rst_out_status", d_out, 64'd0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
